// File: rtl/arith_pkg.sv
// Shared signed-arithmetic helpers and the serial accumulator state type.
package arith_pkg;

   typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} acc_state_t;

   // Bits needed to hold the exact sum of n signed w-bit words.
   function automatic int result_width(input int n, input int w);
      return $clog2(n) + w;
   endfunction

   // Sign-extend the low 'width' bits of val to 64 bits; callers cast down to their result width.
   function automatic logic [63:0] sext_to(input logic [63:0] val, input int width);
      logic [63:0] mask;
      logic        sign;
      mask = {64{1'b1}} << width;
      sign = |(val & (64'd1 << (width - 1)));
      return sign ? (val | mask) : (val & ~mask);
   endfunction

endpackage

// File: rtl/serial_accumulator_signed.sv
// Serial signed accumulator: sums N_INPUTS words per frame, result on a valid/ready stream one cycle after the last word.
// Optional SERIAL_ACC_EARLY_LAST_EN adds in_last to close a frame early (missing words count as zero).
module serial_accumulator_signed
   import arith_pkg::*;
#(
   parameter  int WIDTH     = 4,
   parameter  int N_INPUTS  = 16,
   localparam int OUT_WIDTH = result_width(N_INPUTS, WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
`ifdef SERIAL_ACC_EARLY_LAST_EN
   input  logic                 in_last,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data
);

   localparam int CNT_W = $clog2(N_INPUTS);

   acc_state_t           state_q, state_d;
   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [OUT_WIDTH-1:0] sum;
   logic                 hs;
   logic                 last_word;

   assign sum = acc_q + OUT_WIDTH'(sext_to(64'(in_data), WIDTH));

`ifdef SERIAL_ACC_EARLY_LAST_EN
   assign last_word = (count_q == CNT_W'(N_INPUTS - 1)) || in_last;
`else
   assign last_word = (count_q == CNT_W'(N_INPUTS - 1));
`endif

   assign in_ready  = (state_q == ACCUM) && !rst;
   assign out_valid = (state_q == DONE);
   assign hs        = in_valid && in_ready;
   assign out_data  = out_data_q;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      count_d    = count_q;
      out_data_d = out_data_q;
      case (state_q)
         ACCUM: begin
            if (hs) begin
               if (last_word) begin
                  out_data_d = sum;
                  acc_d      = '0;
                  count_d    = '0;
                  state_d    = DONE;
               end else begin
                  acc_d   = sum;
                  count_d = count_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = ACCUM;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACCUM;
         acc_q      <= '0;
         count_q    <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_serial_accumulator_signed.sv
// Randomised and directed bench for serial_accumulator_signed against a frame-level sum model.
module tb_serial_accumulator_signed;

   localparam int N  = 16;
   localparam int OW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_data = 4'd0;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          man_rdy = 1'b1;
   logic          rnd_rdy = 1'b0;
   bit            rand_rdy = 1'b0;
   logic          model_last;

`ifdef SERIAL_ACC_EARLY_LAST_EN
   logic in_last = 1'b0;
   assign model_last = in_last;
`else
   assign model_last = 1'b0;
`endif

   assign out_ready = rand_rdy ? rnd_rdy : man_rdy;

   serial_accumulator_signed #(.WIDTH(4), .N_INPUTS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef SERIAL_ACC_EARLY_LAST_EN
      .in_last   (in_last),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
   end

   int n_tests = 0;
   int n_fail  = 0;
   int words[$];
   int model_res[$];
   int dut_res[$];
   bit pend = 1'b0;
   int pend_val = 0;
   int msum;
   int exp_consumed = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: collects accepted words, and once a frame closes holds its sum until consumed.
   always @(negedge clk) begin
      check("in_ready", int'(in_ready), int'(!rst && !pend));
      check("out_valid", int'(out_valid), int'(pend));
      if (pend) check("out_data", int'($signed(out_data)), pend_val);
      if (rst) begin
         words.delete();
         pend = 1'b0;
      end else if (pend) begin
         if (out_ready) begin
            dut_res.push_back(int'($signed(out_data)));
            pend = 1'b0;
         end
      end else if (in_valid) begin
         words.push_back(int'($signed(in_data)));
         if (words.size() == N || model_last) begin
            msum = 0;
            foreach (words[i]) msum += words[i];
            words.delete();
            pend     = 1'b1;
            pend_val = msum;
            model_res.push_back(msum);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int w);
      int cnt;
      bit hs;
      cnt = 0;
      hs  = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'(w);
      while (!hs && cnt < 100) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         cnt++;
      end
      if (!hs) check("send_timeout", 0, 1);
      in_valid = 1'b0;
      in_data  = 4'($urandom_range(0, 15));
`ifdef SERIAL_ACC_EARLY_LAST_EN
      in_last  = 1'b0;
`endif
   endtask

   // Waits for the pending result to be taken, then pins the model's sum to a hand-computed value.
   task automatic finish_frame(input string name, input int exp);
      int cnt;
      cnt = 0;
      idle(1);
      while (pend && cnt < 50) begin
         idle(1);
         cnt++;
      end
      if (pend) check({name, "_timeout"}, 0, 1);
      check(name, (model_res.size() > 0) ? model_res[$] : 32'h7fffffff, exp);
      exp_consumed++;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(3);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef SERIAL_ACC_EARLY_LAST_EN
      send(5);
      send(-3);
      in_last = 1'b1;
      send(2);
      finish_frame("early_last", 4);
      for (int i = 0; i < N; i++) send(1);
      finish_frame("after_early", 16);
`endif

      for (int i = 0; i < N; i++) send(i);
      finish_frame("ramp", -8);
      for (int i = 0; i < N; i++) send(8);
      finish_frame("all_min", -128);
      for (int i = 0; i < N; i++) send(7);
      finish_frame("all_max", 112);
      for (int i = 0; i < N; i++) begin
         idle($urandom_range(0, 3));
         send(0);
      end
      finish_frame("zeros_gaps", 0);

      man_rdy = 1'b0;
      for (int i = 0; i < N; i++) send(2);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 4'd7;
         @(negedge clk);
         check("hold_valid", int'(out_valid), 1);
         check("hold_data", int'($signed(out_data)), 32);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      man_rdy  = 1'b1;
      finish_frame("hold_sum", 32);
      for (int i = 0; i < N; i++) send(-2);
      finish_frame("after_hold", -32);

      for (int i = 0; i < 7; i++) send(3);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) send(1);
      finish_frame("post_rst", 16);

      man_rdy = 1'b0;
      for (int i = 0; i < N; i++) send(1);
      idle(1);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      man_rdy = 1'b1;
      @(negedge clk);
      check("donerst_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) send(-2);
      finish_frame("post_done_rst", -32);

      rand_rdy = 1'b1;
      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(int'($urandom_range(0, 15)));
         end
      end
      rand_rdy = 1'b0;
      man_rdy  = 1'b1;
      idle(2);
      for (int c = 0; c < 50 && pend; c++) idle(1);
      exp_consumed += 25;
      check("frames_consumed", dut_res.size(), exp_consumed);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
